// File: rtl/pwm_leg_modulator_pkg.sv
// pwm_pkg: shared state type, default widths and carrier helper for the
// PWM leg modulator (top pwm_leg_modulator, dead-time FSM pwm_deadtime_fsm).
package pwm_pkg;

  // Default carrier/duty/compare width and dead-time counter width.
  localparam int PWM_CW  = 8;
  localparam int PWM_DTW = 8;

  // Leg FSM states: idle, two dead-time states (named by their target) and
  // the two conducting states.
  typedef enum logic [2:0] {
    IDLE,
    DT_TO_HI,
    HI,
    DT_TO_LO,
    LO
  } leg_state_t;

  // Top of the triangle carrier for a given width (2^cw - 1).
  function automatic int unsigned carrier_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_leg_modulator_if.sv
// pwm_leg_modulator_if: per-leg control inputs and gate-drive outputs.
// The master side (controller) drives carrier/duty/deadtime/enable/ce, the
// slave side (the modulator) returns the gate drives and status flags.
interface pwm_leg_modulator_if
  import pwm_pkg::*;
#(
  parameter int CW  = PWM_CW,
  parameter int DTW = PWM_DTW
);

  logic           sys_ce;
  logic           enable;
  logic [CW-1:0]  carrier;
  logic [CW-1:0]  duty;
  logic [DTW-1:0] deadtime;
  logic           gate_hi;
  logic           gate_lo;
  logic           in_deadtime;
  logic           load_strobe;

  modport master (
    output sys_ce, enable, carrier, duty, deadtime,
    input  gate_hi, gate_lo, in_deadtime, load_strobe
  );

  modport slave (
    input  sys_ce, enable, carrier, duty, deadtime,
    output gate_hi, gate_lo, in_deadtime, load_strobe
  );

endinterface

// File: rtl/pwm_leg_modulator_deadtime_fsm.sv
// pwm_deadtime_fsm: turns the registered compare result into complementary
// gate drives with a programmable break-before-make interval. Gates are
// decoded from the state register alone, so they can never overlap.
module pwm_deadtime_fsm
  import pwm_pkg::*;
#(
  parameter int DTW = PWM_DTW
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           i_sysCe,
  input  logic           i_enable,
  input  logic           i_rawQ,
  input  logic [DTW-1:0] i_deadtime,
  output logic           o_gateHi,
  output logic           o_gateLo,
  output logic           o_inDeadtime
);

  leg_state_t     r_state;
  leg_state_t     w_nextState;
  logic [DTW-1:0] r_dtCnt;
  logic [DTW-1:0] w_nextDtCnt;

  // State and dead-time counter registers; frozen whenever the clock enable is low.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_dtCnt <= '0;
    end else if (i_sysCe) begin
      r_state <= w_nextState;
      r_dtCnt <= w_nextDtCnt;
    end
  end

  // Next-state logic: leg disable wins, a reversed compare restarts the dead time.
  always_comb begin
    w_nextState = r_state;
    w_nextDtCnt = r_dtCnt;
    if (!i_enable) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_nextState = i_rawQ ? DT_TO_HI : DT_TO_LO;
          w_nextDtCnt = i_deadtime;
        end
        DT_TO_HI: begin
          if (!i_rawQ) begin
            w_nextState = DT_TO_LO;
            w_nextDtCnt = i_deadtime;
          end else if (r_dtCnt == '0) begin
            w_nextState = HI;
          end else begin
            w_nextDtCnt = r_dtCnt - DTW'(1);
          end
        end
        DT_TO_LO: begin
          if (i_rawQ) begin
            w_nextState = DT_TO_HI;
            w_nextDtCnt = i_deadtime;
          end else if (r_dtCnt == '0) begin
            w_nextState = LO;
          end else begin
            w_nextDtCnt = r_dtCnt - DTW'(1);
          end
        end
        HI: begin
          if (!i_rawQ) begin
            w_nextState = DT_TO_LO;
            w_nextDtCnt = i_deadtime;
          end
        end
        LO: begin
          if (i_rawQ) begin
            w_nextState = DT_TO_HI;
            w_nextDtCnt = i_deadtime;
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // Output decode purely from the registered state.
  always_comb begin
    o_gateHi     = 1'b0;
    o_gateLo     = 1'b0;
    o_inDeadtime = 1'b0;
    case (r_state)
      HI:       o_gateHi     = 1'b1;
      LO:       o_gateLo     = 1'b1;
      DT_TO_HI: o_inDeadtime = 1'b1;
      DT_TO_LO: o_inDeadtime = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/pwm_leg_modulator.sv
// pwm_leg_modulator: one inverter leg. Registers the shared triangle carrier,
// detects the valley (and, with PWM_DOUBLE_UPDATE_EN defined, the peak) to
// load the shadow duty, compares duty against carrier and hands the result to
// the dead-time FSM. Without PWM_DOUBLE_UPDATE_EN no peak logic is built.
module pwm_leg_modulator
  import pwm_pkg::*;
#(
  parameter int CW  = PWM_CW,
  parameter int DTW = PWM_DTW
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  pwm_leg_modulator_if.slave bus
);

  logic [CW-1:0] r_carrierQ;
  logic [CW-1:0] r_dutyAct;
  logic          r_rawQ;
  logic          r_loadStrobe;
  logic          w_valley;
  logic          w_loadEvent;
  logic          w_gateHi;
  logic          w_gateLo;
  logic          w_inDeadtime;

  assign w_valley = (r_carrierQ != '0) && (bus.carrier == '0);

`ifdef PWM_DOUBLE_UPDATE_EN
  localparam logic [CW-1:0] CMAX = CW'(carrier_max(CW));
  logic w_peak;
  assign w_peak      = (r_carrierQ != CMAX) && (bus.carrier == CMAX);
  assign w_loadEvent = w_valley | w_peak;
`else
  assign w_loadEvent = w_valley;
`endif

  // Carrier history, shadow duty load and registered compare; raw uses the pre-load duty.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_carrierQ   <= '0;
      r_dutyAct    <= '0;
      r_rawQ       <= 1'b0;
      r_loadStrobe <= 1'b0;
    end else if (bus.sys_ce) begin
      r_carrierQ   <= bus.carrier;
      r_rawQ       <= (r_dutyAct > bus.carrier);
      r_loadStrobe <= w_loadEvent;
      if (w_loadEvent) begin
        r_dutyAct <= bus.duty;
      end
    end
  end

  pwm_deadtime_fsm #(
    .DTW (DTW)
  ) u_fsm (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .i_sysCe      (bus.sys_ce),
    .i_enable     (bus.enable),
    .i_rawQ       (r_rawQ),
    .i_deadtime   (bus.deadtime),
    .o_gateHi     (w_gateHi),
    .o_gateLo     (w_gateLo),
    .o_inDeadtime (w_inDeadtime)
  );

  assign bus.gate_hi     = w_gateHi;
  assign bus.gate_lo     = w_gateLo;
  assign bus.in_deadtime = w_inDeadtime;
  // The strobe is hidden in stalled cycles so it only ever marks an enabled cycle.
  assign bus.load_strobe = r_loadStrobe & bus.sys_ce;

endmodule

// File: tb/tb_pwm_leg_modulator.sv
// tb_pwm_leg_modulator: scoreboard bench for pwm_leg_modulator. A behavioural
// leg model predicts the outputs at every clock edge and queues them; each
// scenario task pops one prediction per cycle and compares it with the DUT,
// plus scenario-specific timing checks. Honours PWM_DOUBLE_UPDATE_EN.
`timescale 1ns/1ps
module tb_pwm_leg_modulator;
  import pwm_pkg::*;

  localparam int CW  = 8;
  localparam int DTW = 8;

  typedef struct packed {
    logic hi;
    logic lo;
    logic dt;
    logic ls;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   phase   = 0;
  int   plat    = 0;
  exp_t expQ[$];

  pwm_leg_modulator_if #(.CW(CW), .DTW(DTW)) legIf ();

  pwm_leg_modulator #(
    .CW  (CW),
    .DTW (DTW)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (legIf)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural model: active/dead-time/target view of the leg.
  logic [7:0] m_duty, n_duty, m_cprev, n_cprev, m_left, n_left;
  logic       m_raw, n_raw, m_ls, n_ls, m_act, n_act, m_dt, n_dt, m_tgt, n_tgt;
  logic       m_ld;

`ifdef PWM_DOUBLE_UPDATE_EN
  assign m_ld = ((m_cprev != 8'd0) && (legIf.carrier == 8'd0)) ||
                ((m_cprev != 8'd255) && (legIf.carrier == 8'd255));
`else
  assign m_ld = (m_cprev != 8'd0) && (legIf.carrier == 8'd0);
`endif

  // Model next state from the current model state and the driven inputs.
  always_comb begin
    n_duty = m_duty; n_cprev = m_cprev; n_raw = m_raw; n_ls = m_ls;
    n_act = m_act; n_dt = m_dt; n_tgt = m_tgt; n_left = m_left;
    if (sys_rst) begin
      n_duty = '0; n_cprev = '0; n_raw = 1'b0; n_ls = 1'b0;
      n_act = 1'b0; n_dt = 1'b0; n_tgt = 1'b0; n_left = '0;
    end else if (legIf.sys_ce) begin
      n_cprev = legIf.carrier;
      n_raw   = (m_duty > legIf.carrier);
      n_ls    = m_ld;
      if (m_ld) n_duty = legIf.duty;
      if (!legIf.enable) begin
        n_act = 1'b0;
      end else if (!m_act) begin
        n_act = 1'b1; n_dt = 1'b1; n_tgt = m_raw; n_left = legIf.deadtime;
      end else if (m_tgt != m_raw) begin
        n_dt = 1'b1; n_tgt = m_raw; n_left = legIf.deadtime;
      end else if (m_dt) begin
        if (m_left == 8'd0) n_dt = 1'b0;
        else n_left = m_left - 8'd1;
      end
    end
  end

  // Advance the model and queue the outputs expected after this edge.
  always @(posedge sys_clk) begin
    expQ.push_back(exp_t'({n_act & ~n_dt & n_tgt, n_act & ~n_dt & ~n_tgt,
                           n_act & n_dt, n_ls & legIf.sys_ce}));
    m_duty <= n_duty; m_cprev <= n_cprev; m_raw <= n_raw; m_ls <= n_ls;
    m_act <= n_act; m_dt <= n_dt; m_tgt <= n_tgt; m_left <= n_left;
  end

  function automatic logic [7:0] triVal(input int p, input int pl);
    int per;
    int q;
    per = 510 + pl;
    q   = p % per;
    if (q <= 255) return 8'(q);
    if (q <= 255 + pl) return 8'd255;
    return 8'(per - q);
  endfunction

  // One clock: let the edge happen, sample at the falling edge, pop the prediction.
  task automatic applyStimulus(output exp_t e, output exp_t a, output bit g);
    @(posedge sys_clk);
    @(negedge sys_clk);
    a = exp_t'({legIf.gate_hi, legIf.gate_lo, legIf.in_deadtime, legIf.load_strobe});
    g = (expQ.size() > 0);
    e = g ? expQ.pop_front() : exp_t'(4'b0);
  endtask

  task automatic test_reset();
    exp_t e, a;
    bit   g;
    int   dtCount = 0;
    int   loAt = -1;
    int   hiSeen = 0;
    legIf.enable = 1'b1; legIf.duty = 8'd128; legIf.deadtime = 8'd3; legIf.carrier = 8'd0;
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      legIf.sys_ce = (i != 0);
      applyStimulus(e, a, g);
      checks++;
      if (a !== exp_t'(4'b0)) begin
        errors++; $display("[TB] FAIL reset_outputs cyc=%0d got=%b required=0000", i, a);
      end
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL reset_model cyc=%0d got=%b required=%b", i, a, e);
      end
    end
    sys_rst = 1'b0; legIf.sys_ce = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL release_model cyc=%0d got=%b required=%b", s, a, e);
      end
      if (a.dt) dtCount++;
      if (a.hi) hiSeen++;
      if (a.lo && loAt < 0) loAt = s;
    end
    checks++;
    if (dtCount != 4 || loAt != 5 || hiSeen != 0) begin
      errors++;
      $display("[TB] FAIL first_gate dt=%0d lo_at=%0d hi=%0d required dt=4 lo_at=5 hi=0", dtCount, loAt, hiSeen);
    end
  endtask

  task automatic test_steady_pwm();
    exp_t e, a;
    bit   g;
    int   run = 0;
    int   nHi = 0, nLo = 0, nDt = 0;
    legIf.duty = 8'd64; legIf.deadtime = 8'd3; phase = 0; plat = 0;
    for (int i = 0; i < 1110; i++) begin
      legIf.carrier = triVal(phase, plat); phase++;
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL steady_model cyc=%0d got=%b required=%b", i, a, e);
      end
      checks++;
      if (a.hi && a.lo) begin
        errors++; $display("[TB] FAIL steady_overlap cyc=%0d got hi=1 lo=1 required not both", i);
      end
      if (a.dt) run++;
      else begin
        if (run != 0) begin
          checks++;
          if (run != 4) begin
            errors++; $display("[TB] FAIL steady_dt_len cyc=%0d got=%0d required=4", i, run);
          end
        end
        run = 0;
      end
      if (i >= 600) begin
        nHi += a.hi; nLo += a.lo; nDt += a.dt;
      end
    end
    checks++;
    if (nHi != 123 || nLo != 379 || nDt != 8) begin
      errors++;
      $display("[TB] FAIL steady_period got hi=%0d lo=%0d dt=%0d required 123/379/8", nHi, nLo, nDt);
    end
  endtask

  task automatic test_shadow_load();
    exp_t e, a;
    bit   g;
    int   nStrobe = 0, expStrobe;
    int   nHi = 0, nLo = 0, nDt = 0;
    int   pre;
`ifdef PWM_DOUBLE_UPDATE_EN
    expStrobe = 2;
`else
    expStrobe = 1;
`endif
    pre = (100 - (phase % 510) + 510) % 510;
    for (int i = 0; i < pre + 1020; i++) begin
      if (i == pre) legIf.duty = 8'd192;
      legIf.carrier = triVal(phase, plat); phase++;
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL shadow_model cyc=%0d got=%b required=%b", i, a, e);
      end
      if (a.ls) begin
        checks++;
        if (legIf.carrier != 8'd0
`ifdef PWM_DOUBLE_UPDATE_EN
            && legIf.carrier != 8'd255
`endif
           ) begin
          errors++; $display("[TB] FAIL strobe_position got carrier=%0d required load step", legIf.carrier);
        end
      end
      if (i >= pre && i < pre + 510) nStrobe += a.ls;
      if (i >= pre + 510) begin
        nHi += a.hi; nLo += a.lo; nDt += a.dt;
      end
    end
    checks++;
    if (nStrobe != expStrobe) begin
      errors++; $display("[TB] FAIL shadow_strobes got=%0d required=%0d", nStrobe, expStrobe);
    end
    checks++;
    if (nHi != 379 || nLo != 123 || nDt != 8) begin
      errors++;
      $display("[TB] FAIL shadow_period got hi=%0d lo=%0d dt=%0d required 379/123/8", nHi, nLo, nDt);
    end
  endtask

  task automatic test_extremes();
    exp_t e, a;
    bit   g;
    int   nHi = 0, nLo = 0, nDt = 0;
    legIf.duty = 8'd0;
    for (int i = 0; i < 1110; i++) begin
      legIf.carrier = triVal(phase, plat); phase++;
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL duty0_model cyc=%0d got=%b required=%b", i, a, e);
      end
      if (i >= 600) begin
        nHi += a.hi; nLo += a.lo; nDt += a.dt;
      end
    end
    checks++;
    if (nHi != 0 || nLo != 510 || nDt != 0) begin
      errors++; $display("[TB] FAIL duty0_period got hi=%0d lo=%0d dt=%0d required 0/510/0", nHi, nLo, nDt);
    end
    legIf.duty = 8'd255; phase = 0; plat = 7;
    nHi = 0; nLo = 0; nDt = 0;
    for (int i = 0; i < 1117; i++) begin
      legIf.carrier = triVal(phase, plat); phase++;
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL duty255_model cyc=%0d got=%b required=%b", i, a, e);
      end
      if (i >= 600) begin
        nHi += a.hi; nLo += a.lo; nDt += a.dt;
      end
    end
    checks++;
    if (nHi != 505 || nLo != 4 || nDt != 8) begin
      errors++; $display("[TB] FAIL duty255_period got hi=%0d lo=%0d dt=%0d required 505/4/8", nHi, nLo, nDt);
    end
  endtask

  task automatic test_deadtime_abort();
    exp_t e, a;
    bit   g;
    int   dtCount = 0, hiSeen = 0, loAt = -1;
    legIf.deadtime = 8'd10; legIf.carrier = 8'd255;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL abort_setup cyc=%0d got=%b required=%b", i, a, e);
      end
    end
    checks++;
    if (a.lo !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_start_lo got=%b required=1", a.lo);
    end
    for (int k = 1; k <= 20; k++) begin
      legIf.carrier = (k <= 4) ? 8'd100 : 8'd255;
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL abort_model cyc=%0d got=%b required=%b", k, a, e);
      end
      dtCount += a.dt;
      hiSeen  += a.hi;
      if (k >= 2 && a.lo && loAt < 0) loAt = k;
    end
    checks++;
    if (dtCount != 15 || hiSeen != 0 || loAt != 17) begin
      errors++;
      $display("[TB] FAIL abort_restart got dt=%0d hi=%0d lo_at=%0d required dt=15 hi=0 lo_at=17", dtCount, hiSeen, loAt);
    end
    legIf.enable = 1'b0;
    applyStimulus(e, a, g);
    checks++;
    if (!g || a !== e || {a.hi, a.lo, a.dt} !== 3'b000) begin
      errors++; $display("[TB] FAIL disable_idle got=%b required=%b", a, e);
    end
  endtask

  task automatic test_clock_enable();
    exp_t e, a, prev;
    bit   g;
    bit   prevDt;
    int   enabledDt = 0;
    legIf.deadtime = 8'd5; legIf.carrier = 8'd255; legIf.enable = 1'b1;
    prev = exp_t'(4'b0);
    prevDt = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      legIf.sys_ce = k[0];
      applyStimulus(e, a, g);
      checks++;
      if (!g || a !== e) begin
        errors++; $display("[TB] FAIL ce_model cyc=%0d got=%b required=%b", k, a, e);
      end
      if (legIf.sys_ce && prevDt) enabledDt++;
      if (!legIf.sys_ce) begin
        checks++;
        if ({a.hi, a.lo, a.dt} !== {prev.hi, prev.lo, prev.dt} || a.ls !== 1'b0) begin
          errors++; $display("[TB] FAIL ce_hold cyc=%0d got=%b required=%b with ls=0", k, a, prev);
        end
      end
      prevDt = a.dt;
      prev = a;
    end
    checks++;
    if (enabledDt != 6 || a.lo !== 1'b1) begin
      errors++; $display("[TB] FAIL ce_interval got=%0d lo=%b required=6 lo=1", enabledDt, a.lo);
    end
    legIf.sys_ce = 1'b1;
  endtask

  initial begin
    legIf.sys_ce = 1'b0; legIf.enable = 1'b0; legIf.carrier = 8'd0;
    legIf.duty = 8'd0; legIf.deadtime = 8'd0;
    test_reset();
    test_steady_pwm();
    test_shadow_load();
    test_extremes();
    test_deadtime_abort();
    test_clock_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
